// File: rtl/mips_boot_loader.sv
// Byte-stream program loader: takes a little-endian word count and the program words,
// writes them into the core's combined memory and then lets the core out of reset.
module mips_boot_loader #(
  parameter int unsigned CELL_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned MAX_WORDS  = 10000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CELL_WIDTH-1:0] mem_wd,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CELL_WIDTH-1:0] MAX_N = CELL_WIDTH'(MAX_WORDS);

  state_t                  state;
  logic [1:0]              byte_cnt;
  logic [CELL_WIDTH-9:0]   shift_reg;
  logic [CELL_WIDTH-1:0]   n_words;
  logic [CELL_WIDTH-1:0]   word;
  logic [ADDR_WIDTH-1:0]   words_next;
  logic                    accept;

  // in_ready is a pure state decode so a stalled producer sees it in the same cycle.
  assign in_ready   = (state == S_HDR) || (state == S_LOAD);
  assign accept     = in_valid && in_ready;
  // Earlier bytes sit in the low lanes, so the incoming byte lands in [31:24].
  assign word       = {in_data, shift_reg};
  assign words_next = words_loaded + ADDR_WIDTH'(1);

  // NOTE: every state register below uses non-blocking assignment so all of them
  // update together at the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_HDR;
      byte_cnt     <= '0;
      shift_reg    <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE;
      mem_wd       <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt  <= byte_cnt + 2'd1;
        shift_reg <= word[CELL_WIDTH-1:8];
      end

      case (state)
        S_HDR: begin
          if (accept && byte_cnt == 2'd3) begin
            n_words <= word;
            if (word != '0 && word <= MAX_N) begin
              state <= S_LOAD;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept && byte_cnt == 2'd3) begin
            state    <= S_WRITE;
            mem_we   <= 1'b1;
            mem_wd   <= word;
            mem_addr <= BASE + (words_loaded << 2);
          end
        end

        S_WRITE: begin
          mem_we       <= 1'b0;
          words_loaded <= words_next;
          if (CELL_WIDTH'(words_next) == n_words) begin
            state   <= S_DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= S_LOAD;
          end
        end

        S_DONE: state <= S_DONE;

        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: a stream-level model predicts every output each
// cycle, and literal expectations pin the written addresses/data of each scenario.
module tb_mips_boot_loader;

  localparam int unsigned MAX_WORDS = 10000;
  localparam logic [31:0] BASE      = 32'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [31:0] words_loaded;

  mips_boot_loader #(
    .CELL_WIDTH(32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (0),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream-level reference model ----------------
  // Everything is derived from how many bytes were accepted since reset:
  // bytes 0..3 form N, each further group of 4 forms one program word.
  bit          model_ok = 1'b0;
  int          acc;
  logic [7:0]  grp [4];
  logic [31:0] hdr_n;
  int          written;
  bit          m_we;
  logic [31:0] last_addr;
  logic [31:0] last_wd;

  function automatic bit m_err();
    return (acc >= 4) && (hdr_n == 0 || hdr_n > MAX_WORDS);
  endfunction

  function automatic bit m_done();
    return (acc >= 4) && !m_err() && (32'(written) == hdr_n);
  endfunction

  function automatic bit m_ready();
    return !m_err() && !m_done() && !m_we;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      model_ok  = 1'b1;
      acc       = 0;
      hdr_n     = '0;
      written   = 0;
      m_we      = 1'b0;
      last_addr = BASE;
      last_wd   = '0;
    end else if (model_ok) begin
      bit take;
      take = in_valid && m_ready();
      if (m_we) begin
        written++;
        m_we = 1'b0;
      end
      if (take) begin
        grp[acc % 4] = in_data;
        acc++;
        if (acc % 4 == 0) begin
          if (acc == 4) begin
            hdr_n = {grp[3], grp[2], grp[1], grp[0]};
          end else begin
            m_we      = 1'b1;
            last_addr = BASE + 32'(4 * written);
            last_wd   = {grp[3], grp[2], grp[1], grp[0]};
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wr_log [$];

  // Single compare process: all outputs against the model, away from the active edge.
  always @(negedge CLK) begin
    if (model_ok) begin
      check("in_ready",     in_ready,     m_ready());
      check("mem_we",       mem_we,       m_we);
      check("mem_addr",     mem_addr,     last_addr);
      check("mem_wd",       mem_wd,       last_wd);
      check("done",         done,         m_done());
      check("error",        error,        m_err());
      check("cpu_rst",      cpu_rst,      !m_done());
      check("words_loaded", words_loaded, 32'(written));
      if (mem_we) wr_log.push_back('{a: mem_addr, d: mem_wd});
    end
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic do_reset();
    RST      = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    wr_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    bit r;
    in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      r = in_ready;
      @(negedge CLK);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte_accepted", ok, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- single word, back-to-back ----
    do_reset();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cpu_rst",  cpu_rst,  1'b1);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd",   mem_wd,   32'h0);
    check("rst_words",    words_loaded, 32'h0);
    send_word(32'h0000_0001, 0);
    send_word(32'h1234_5678, 0);
    in_valid = 1'b0;
    check("t1_we",   mem_we,   1'b1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_wd",   mem_wd,   32'h1234_5678);
    check("t1_rdy",  in_ready, 1'b0);
    @(negedge CLK);
    check("t1_done",  done,         1'b1);
    check("t1_cpu",   cpu_rst,      1'b0);
    check("t1_words", words_loaded, 32'd1);
    check("t1_nwr",   32'(wr_log.size()), 32'd1);

    // ---- three words with idle gaps ----
    do_reset();
    send_word(32'd3, 3);
    send_word(32'h2008_0005, 3);
    send_word(32'h2109_0003, 3);
    send_word(32'hAC09_0000, 3);
    idle(3);
    check("t2_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      check("t2_a0", wr_log[0].a, 32'h0);
      check("t2_d0", wr_log[0].d, 32'h2008_0005);
      check("t2_a1", wr_log[1].a, 32'h4);
      check("t2_d1", wr_log[1].d, 32'h2109_0003);
      check("t2_a2", wr_log[2].a, 32'h8);
      check("t2_d2", wr_log[2].d, 32'hAC09_0000);
    end
    check("t2_done", done, 1'b1);

    // ---- N = 0 is rejected ----
    do_reset();
    send_word(32'd0, 0);
    check("t3_err", error,    1'b1);
    check("t3_cpu", cpu_rst,  1'b1);
    check("t3_rdy", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (5) @(negedge CLK);
    in_valid = 1'b0;
    check("t3_nwr", 32'(wr_log.size()), 32'd0);

    // ---- N = MAX_WORDS+1 rejected, N = MAX_WORDS accepted ----
    do_reset();
    send_word(32'd10001, 2);
    in_valid = 1'b0;
    check("t4_err", error,   1'b1);
    check("t4_cpu", cpu_rst, 1'b1);
    do_reset();
    send_word(32'd10000, 2);
    in_valid = 1'b0;
    check("t4_max_rdy", in_ready, 1'b1);
    check("t4_max_err", error,    1'b0);
    send_word(32'hCAFE_F00D, 0);
    in_valid = 1'b0;
    check("t4_we", mem_we, 1'b1);
    check("t4_wd", mem_wd, 32'hCAFE_F00D);
    @(negedge CLK);
    check("t4_words", words_loaded, 32'd1);
    check("t4_done",  done,         1'b0);

    // ---- reset in the middle of a load, then a fresh stream ----
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1111_2222, 1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    do_reset();
    check("t5_cpu",   cpu_rst,      1'b1);
    check("t5_words", words_loaded, 32'd0);
    check("t5_done",  done,         1'b0);
    check("t5_we",    mem_we,       1'b0);
    check("t5_addr",  mem_addr,     32'h0);
    check("t5_wd",    mem_wd,       32'h0);
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 2);
    idle(2);
    check("t5_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) begin
      check("t5_a0", wr_log[0].a, 32'h0);
      check("t5_d0", wr_log[0].d, 32'hDEAD_BEEF);
    end
    check("t5_fin", done, 1'b1);

    // ---- stream bytes offered in DONE are ignored ----
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("t6_rdy",  in_ready, 1'b0);
      check("t6_we",   mem_we,   1'b0);
      check("t6_done", done,     1'b1);
      check("t6_cpu",  cpu_rst,  1'b0);
    end
    in_valid = 1'b0;
    check("t6_nwr", 32'(wr_log.size()), 32'd1);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
